// File: rtl/decode_pkg.sv
// Shared decode types and helpers for the RV32 decode stage.
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // funct3 of the shift-right immediates, the only I-ops that carry funct7
  localparam logic [2:0] F3_SHIFT_R = 3'b101;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;

  // Fully decoded view of one instruction word; unused fields are zero.
  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_used;
    logic        rs2_used;
    logic        rd_write;
    logic        illegal;
    logic [31:0] imm;
  } decode_fields_t;

  // True when a register index exists in a file of nregs entries.
  function automatic logic idx_ok(logic [4:0] idx, int nregs);
    return {27'd0, idx} < nregs[31:0];
  endfunction

  // 32-bit sign-extended immediate for the given format.
  function automatic logic [31:0] imm_of(logic [31:0] instr, imm_type_e t);
    logic [31:0] imm;
    case (t)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'b0;
    endcase
    return imm;
  endfunction

  // Pure combinational decode of one instruction word.
  function automatic decode_fields_t decode(logic [31:0] instr, int nregs);
    decode_fields_t f;
    imm_type_e      t;
    logic           legal_op;
    logic           writes_rd;
    f         = '0;
    t         = IMM_NONE;
    legal_op  = 1'b1;
    writes_rd = 1'b0;
    case (instr[6:0])
      OP_R:              begin f.rs1_used = 1'b1; f.rs2_used = 1'b1; writes_rd = 1'b1; end
      OP_IMM, OP_LOAD:   begin t = IMM_I; f.rs1_used = 1'b1; writes_rd = 1'b1; end
      OP_STORE:          begin t = IMM_S; f.rs1_used = 1'b1; f.rs2_used = 1'b1; end
      OP_BRANCH:         begin t = IMM_B; f.rs1_used = 1'b1; f.rs2_used = 1'b1; end
      OP_LUI, OP_AUIPC:  begin t = IMM_U; writes_rd = 1'b1; end
      OP_JAL:            begin t = IMM_J; writes_rd = 1'b1; end
      default:           legal_op = 1'b0;
    endcase
    f.opcode  = instr[6:0];
    f.funct3  = f.rs1_used ? instr[14:12] : 3'b0;
    f.funct7  = (f.opcode == OP_R || (f.opcode == OP_IMM && instr[14:12] == F3_SHIFT_R))
                ? instr[31:25] : 7'b0;
    f.rs1     = f.rs1_used ? instr[19:15] : 5'd0;
    f.rs2     = f.rs2_used ? instr[24:20] : 5'd0;
    f.rd      = writes_rd  ? instr[11:7]  : 5'd0;
    f.illegal = !legal_op
                || (f.rs1_used && !idx_ok(f.rs1, nregs))
                || (f.rs2_used && !idx_ok(f.rs2, nregs))
                || (writes_rd  && !idx_ok(f.rd,  nregs));
    f.rd_write = writes_rd && !f.illegal;
    f.imm      = imm_of(instr, t);
    return f;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side, writeback and execute-side signals of the decode stage.
interface decode_stage_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            wb_write;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_value;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_rs1_value;
  logic [XLEN-1:0] out_rs2_value;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [4:0]      out_rd;
  logic            out_rd_write;
  logic            out_illegal;

  // Surroundings (fetch, writeback, execute) drive the stage.
  modport master (
    output in_valid, in_instr, in_pc, flush, wb_write, wb_rd, wb_value, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_rs1_value, out_rs2_value,
           out_opcode, out_funct3, out_funct7, out_rd, out_rd_write, out_illegal
  );

  // The decode stage itself.
  modport slave (
    input  in_valid, in_instr, in_pc, flush, wb_write, wb_rd, wb_value, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_rs1_value, out_rs2_value,
           out_opcode, out_funct3, out_funct7, out_rd, out_rd_write, out_illegal
  );
endinterface

// File: rtl/decode_regfile.sv
// Architectural register file: two read ports, one write port, optional
// same-cycle writeback forwarding. x0 and out-of-range indices read 0.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en_i,
  input  logic [4:0]           wr_addr_i,
  input  logic [XLEN-1:0]      wr_data_i,
  input  logic [1:0][4:0]      rd_addr_i,
  output logic [1:0][XLEN-1:0] rd_data_o
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_ok;

  assign wr_ok = wr_en_i && (wr_addr_i != 5'd0) && idx_ok(wr_addr_i, NREGS);

  // Register storage; writes to x0 or beyond the file are discarded.
  // NOTE: the array is reset because every register must read 0 during reset;
  // a plain RAM without reset would not give that guarantee. Sequential state
  // uses <= so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[wr_addr_i[AW-1:0]] <= wr_data_i;
    end
  end

  // Read ports with optional writeback forwarding.
  // NOTE: each output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data_o[p] = '0;
      if (rd_addr_i[p] != 5'd0 && idx_ok(rd_addr_i[p], NREGS)) begin
        if (BYPASS != 0 && wr_en_i && wr_addr_i == rd_addr_i[p]) rd_data_o[p] = wr_data_i;
        else                                                    rd_data_o[p] = regs_q[rd_addr_i[p][AW-1:0]];
      end
    end
  end
endmodule

// File: rtl/decode_stage.sv
// RV32 decode stage: combinational decode, one pipeline register, load-use
// stall detection and flush. Clock port is req, active-low async reset is reset.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input  logic          req,
  input  logic          reset,
  decode_stage_if.slave bus
);
  decode_fields_t        dec;
  logic [1:0][4:0]       rd_addr;
  logic [1:0][XLEN-1:0]  rd_data;
  logic [XLEN-1:0]       imm_ext;
  logic                  hazard;
  logic                  in_ready;
  logic                  accept;

  logic            valid_q,    valid_d;
  logic [XLEN-1:0] pc_q,       pc_d;
  logic [XLEN-1:0] imm_q,      imm_d;
  logic [XLEN-1:0] rs1_q,      rs1_d;
  logic [XLEN-1:0] rs2_q,      rs2_d;
  logic [6:0]      opcode_q,   opcode_d;
  logic [2:0]      funct3_q,   funct3_d;
  logic [6:0]      funct7_q,   funct7_d;
  logic [4:0]      rd_q,       rd_d;
  logic            rd_write_q, rd_write_d;
  logic            illegal_q,  illegal_d;

  // Decode the offered instruction.
  always_comb dec = decode(bus.in_instr, NREGS);

  assign rd_addr = {dec.rs2, dec.rs1};
  assign imm_ext = XLEN'(signed'(dec.imm));

  decode_regfile #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(BYPASS)) u_regfile (
    .clk       (req),
    .rst_n     (reset),
    .wr_en_i   (bus.wb_write),
    .wr_addr_i (bus.wb_rd),
    .wr_data_i (bus.wb_value),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // Load-use: the held load's result is not yet available to the offered instruction.
  always_comb begin
    hazard = valid_q && (opcode_q == OP_LOAD) && (rd_q != 5'd0) && bus.in_valid
             && ((dec.rs1_used && dec.rs1 == rd_q) || (dec.rs2_used && dec.rs2 == rd_q));
    in_ready = (!valid_q || bus.out_ready) && !hazard && !bus.flush;
    accept   = bus.in_valid && in_ready;
  end

  // Next state: flush empties, a transfer loads, consumption empties, otherwise hold.
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    opcode_d   = opcode_q;
    funct3_d   = funct3_q;
    funct7_d   = funct7_q;
    rd_d       = rd_q;
    rd_write_d = rd_write_q;
    illegal_d  = illegal_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d    = 1'b1;
      pc_d       = bus.in_pc;
      imm_d      = imm_ext;
      rs1_d      = rd_data[0];
      rs2_d      = rd_data[1];
      opcode_d   = dec.opcode;
      funct3_d   = dec.funct3;
      funct7_d   = dec.funct7;
      rd_d       = dec.rd;
      rd_write_d = dec.rd_write;
      illegal_d  = dec.illegal;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Pipeline register holding the decoded instruction.
  always_ff @(posedge req or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      opcode_q   <= '0;
      funct3_q   <= '0;
      funct7_q   <= '0;
      rd_q       <= '0;
      rd_write_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      opcode_q   <= opcode_d;
      funct3_q   <= funct3_d;
      funct7_q   <= funct7_d;
      rd_q       <= rd_d;
      rd_write_q <= rd_write_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = valid_q;
  assign bus.out_pc        = pc_q;
  assign bus.out_imm       = imm_q;
  assign bus.out_rs1_value = rs1_q;
  assign bus.out_rs2_value = rs2_q;
  assign bus.out_opcode    = opcode_q;
  assign bus.out_funct3    = funct3_q;
  assign bus.out_funct7    = funct7_q;
  assign bus.out_rd        = rd_q;
  assign bus.out_rd_write  = rd_write_q;
  assign bus.out_illegal   = illegal_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: dut_a is RV32I with forwarding, dut_b is
// RV32E (16 registers) without forwarding; both see the same stimulus.
module tb_decode_stage;
  localparam logic [31:0] I_ADDI_X1_X0_5  = 32'h0050_0093;
  localparam logic [31:0] I_ADDI_X5_X4_4  = 32'h0042_0293;
  localparam logic [31:0] I_LW_X2_0_X1    = 32'h0000_A103;
  localparam logic [31:0] I_ADD_X3_X2_X2  = 32'h0021_01B3;
  localparam logic [31:0] I_LUI_X6        = 32'h1234_5337;
  localparam logic [31:0] I_BEQ_M4        = 32'hFE20_8EE3;
  localparam logic [31:0] I_ADD_X20_X1_X2 = 32'h0020_8A33;
  localparam logic [31:0] I_BAD_OP        = 32'h0000_007F;

  logic req;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  decode_stage_if #(.XLEN(32)) bus_a ();
  decode_stage_if #(.XLEN(32)) bus_b ();

  decode_stage #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut_a (.req(req), .reset(reset), .bus(bus_a));
  decode_stage #(.XLEN(32), .NREGS(16), .BYPASS(0)) dut_b (.req(req), .reset(reset), .bus(bus_b));

  assign bus_b.in_valid  = bus_a.in_valid;
  assign bus_b.in_instr  = bus_a.in_instr;
  assign bus_b.in_pc     = bus_a.in_pc;
  assign bus_b.flush     = bus_a.flush;
  assign bus_b.wb_write  = bus_a.wb_write;
  assign bus_b.wb_rd     = bus_a.wb_rd;
  assign bus_b.wb_value  = bus_a.wb_value;
  assign bus_b.out_ready = bus_a.out_ready;

  initial begin
    req = 1'b0;
    forever #5 req = ~req;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge req);
    #1;
  endtask

  initial begin
    reset           = 1'b0;
    bus_a.in_valid  = 1'b0;
    bus_a.in_instr  = '0;
    bus_a.in_pc     = '0;
    bus_a.flush     = 1'b0;
    bus_a.wb_write  = 1'b0;
    bus_a.wb_rd     = '0;
    bus_a.wb_value  = '0;
    bus_a.out_ready = 1'b0;

    // Reset state
    #2;
    check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_out_pc", bus_a.out_pc, 32'd0);
    check("rst_out_imm", bus_a.out_imm, 32'd0);
    check("rst_out_rd_write", 32'(bus_a.out_rd_write), 32'd0);
    #10;

    // Release reset and offer ADDI x1,x0,5 while writing x0 (must stay zero)
    reset           = 1'b1;
    bus_a.in_valid  = 1'b1;
    bus_a.in_instr  = I_ADDI_X1_X0_5;
    bus_a.in_pc     = 32'h100;
    bus_a.out_ready = 1'b1;
    bus_a.wb_write  = 1'b1;
    bus_a.wb_rd     = 5'd0;
    bus_a.wb_value  = 32'h55;
    #1;
    check("post_rst_in_ready", 32'(bus_a.in_ready), 32'd1);
    tick();
    check("addi_valid", 32'(bus_a.out_valid), 32'd1);
    check("addi_imm", bus_a.out_imm, 32'd5);
    check("addi_rd", 32'(bus_a.out_rd), 32'd1);
    check("addi_rd_write", 32'(bus_a.out_rd_write), 32'd1);
    check("addi_rs1_x0", bus_a.out_rs1_value, 32'd0);
    check("addi_pc", bus_a.out_pc, 32'h100);
    check("addi_opcode", 32'(bus_a.out_opcode), 32'h13);

    // Load x4 = 0x1111 and x2 = 0x22 through writeback
    bus_a.in_valid = 1'b0;
    bus_a.wb_rd    = 5'd4;
    bus_a.wb_value = 32'h1111;
    tick();
    check("drain_valid", 32'(bus_a.out_valid), 32'd0);
    bus_a.wb_rd    = 5'd2;
    bus_a.wb_value = 32'h22;
    tick();

    // Same-cycle writeback of x4 while ADDI x5,x4,4 reads it
    bus_a.wb_rd    = 5'd4;
    bus_a.wb_value = 32'hDEAD;
    bus_a.in_valid = 1'b1;
    bus_a.in_instr = I_ADDI_X5_X4_4;
    bus_a.in_pc    = 32'h104;
    tick();
    check("bypass_on_rs1", bus_a.out_rs1_value, 32'hDEAD);
    check("bypass_off_rs1", bus_b.out_rs1_value, 32'h1111);
    check("itype_rs2_unused", bus_a.out_rs2_value, 32'd0);
    check("addi4_imm", bus_a.out_imm, 32'd4);
    bus_a.wb_write = 1'b0;

    // Load-use: LW x2 then ADD x3,x2,x2
    bus_a.in_instr = I_LW_X2_0_X1;
    bus_a.in_pc    = 32'h108;
    #3;
    check("lw_in_ready", 32'(bus_a.in_ready), 32'd1);
    tick();
    check("lw_valid", 32'(bus_a.out_valid), 32'd1);
    check("lw_opcode", 32'(bus_a.out_opcode), 32'h03);
    bus_a.in_instr = I_ADD_X3_X2_X2;
    bus_a.in_pc    = 32'h10C;
    #3;
    check("hazard_in_ready", 32'(bus_a.in_ready), 32'd0);
    tick();
    check("bubble_valid", 32'(bus_a.out_valid), 32'd0);
    #3;
    check("after_bubble_in_ready", 32'(bus_a.in_ready), 32'd1);
    tick();
    check("add_valid", 32'(bus_a.out_valid), 32'd1);
    check("add_pc", bus_a.out_pc, 32'h10C);
    check("add_rd", 32'(bus_a.out_rd), 32'd3);
    check("add_rs1", bus_a.out_rs1_value, 32'h22);
    check("add_rs2", bus_a.out_rs2_value, 32'h22);
    check("add_funct7", 32'(bus_a.out_funct7), 32'd0);

    // Three-cycle stall with LUI offered
    bus_a.out_ready = 1'b0;
    bus_a.in_instr  = I_LUI_X6;
    bus_a.in_pc     = 32'h110;
    #3;
    check("stall_in_ready", 32'(bus_a.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", 32'(bus_a.out_valid), 32'd1);
      check("stall_pc", bus_a.out_pc, 32'h10C);
      check("stall_opcode", 32'(bus_a.out_opcode), 32'h33);
      check("stall_rs2", bus_a.out_rs2_value, 32'h22);
    end
    bus_a.out_ready = 1'b1;
    tick();
    check("lui_valid", 32'(bus_a.out_valid), 32'd1);
    check("lui_pc", bus_a.out_pc, 32'h110);
    check("lui_imm", bus_a.out_imm, 32'h1234_5000);
    check("lui_rd", 32'(bus_a.out_rd), 32'd6);
    check("lui_rd_write", 32'(bus_a.out_rd_write), 32'd1);

    // Flush during a stall drops both held and offered instructions
    bus_a.out_ready = 1'b0;
    bus_a.in_instr  = I_BEQ_M4;
    bus_a.in_pc     = 32'h114;
    tick();
    check("pre_flush_pc", bus_a.out_pc, 32'h110);
    bus_a.flush = 1'b1;
    #3;
    check("flush_in_ready", 32'(bus_a.in_ready), 32'd0);
    tick();
    check("flush_valid", 32'(bus_a.out_valid), 32'd0);
    bus_a.flush     = 1'b0;
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    tick();
    check("flush_dropped", 32'(bus_a.out_valid), 32'd0);

    // BEQ x1,x2,-4
    bus_a.in_valid = 1'b1;
    bus_a.in_pc    = 32'h118;
    tick();
    check("beq_valid", 32'(bus_a.out_valid), 32'd1);
    check("beq_imm", bus_a.out_imm, 32'hFFFF_FFFC);
    check("beq_rd_write", 32'(bus_a.out_rd_write), 32'd0);
    check("beq_rs2", bus_a.out_rs2_value, 32'h22);

    // ADD x20,x1,x2: legal with 32 registers, illegal with 16
    bus_a.in_instr = I_ADD_X20_X1_X2;
    bus_a.in_pc    = 32'h11C;
    tick();
    check("x20_a_illegal", 32'(bus_a.out_illegal), 32'd0);
    check("x20_a_rd_write", 32'(bus_a.out_rd_write), 32'd1);
    check("x20_a_rd", 32'(bus_a.out_rd), 32'd20);
    check("x20_b_illegal", 32'(bus_b.out_illegal), 32'd1);
    check("x20_b_rd_write", 32'(bus_b.out_rd_write), 32'd0);

    // Unknown opcode 0x7F
    bus_a.in_instr = I_BAD_OP;
    bus_a.in_pc    = 32'h120;
    tick();
    check("op7f_valid", 32'(bus_a.out_valid), 32'd1);
    check("op7f_a_illegal", 32'(bus_a.out_illegal), 32'd1);
    check("op7f_a_rd_write", 32'(bus_a.out_rd_write), 32'd0);
    check("op7f_b_illegal", 32'(bus_b.out_illegal), 32'd1);
    check("op7f_imm", bus_a.out_imm, 32'd0);

    // Reset asserted mid-stall clears everything immediately
    bus_a.out_ready = 1'b0;
    bus_a.in_instr  = I_ADDI_X5_X4_4;
    bus_a.in_pc     = 32'h124;
    tick();
    check("hold_before_rst", 32'(bus_a.out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus_a.out_valid), 32'd0);
    check("async_rst_pc", bus_a.out_pc, 32'd0);
    check("async_rst_illegal", 32'(bus_a.out_illegal), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("rst_release_in_ready", 32'(bus_a.in_ready), 32'd1);
    tick();
    check("regs_cleared_valid", 32'(bus_a.out_valid), 32'd1);
    check("regs_cleared_a_rs1", bus_a.out_rs1_value, 32'd0);
    check("regs_cleared_b_rs1", bus_b.out_rs1_value, 32'd0);
    check("regs_cleared_pc", bus_a.out_pc, 32'h124);

    bus_a.in_valid = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
